icap_stream_writer: RTL and testbench



---
 rtl/icap_stream_pkg.sv | 35 +++
 rtl/icap_word_fifo.sv | 66 ++++++
 rtl/icap_stream_writer.sv | 216 +++++++++++++++++++++
 tb/tb_icap_stream_writer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icap_stream_pkg.sv
// icap_stream_pkg
// Shared types and helpers for the ICAP stream writer:
//   state_t    - writer FSM states
//   ERR_*      - err_code encodings reported to the register slave
//   bitswap32  - reverses bit order inside each byte of a 32-bit word
package icap_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    HOLD,
    WAIT_DONE,
    DISCARD,
    DONE
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_PRERROR = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  // ICAP expects each byte bit-reversed relative to the bitstream file order.
  function automatic logic [31:0] bitswap32(input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 8; b++) begin
        r[8*k+b] = d[8*k+7-b];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/icap_word_fifo.sv
// icap_word_fifo
// Synchronous word FIFO with first-word-fall-through head output.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   push, din   - write a word (accepted when not full, or when popping too)
//   pop, dout   - dout is the current head; pop removes it
//   flush       - drop all contents; takes priority over push/pop
//   full, empty - occupancy flags
module icap_word_fifo
  import icap_stream_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/icap_stream_writer.sv
// icap_stream_writer
// Buffers partial-bitstream words from the AXI read master, bit-swaps them
// and writes them to ICAPE3 with CSIB/RDWRB sequencing, then reports the
// PRDONE/PRERROR outcome.
// Ports:
//   ACLK, ARESET                - clock, asynchronous active-high reset
//   start, abort, word_count    - control from the register slave
//   s_tdata/s_tvalid/s_tready   - bitstream word stream
//   icap_csib/rdwrb/i           - registered ICAPE3 write port
//   icap_avail/prdone/prerror   - ICAPE3 status
//   busy, done, error, err_code - transfer status (done/error held until start)
//   words_sent                  - words written to ICAP in this transfer
module icap_stream_writer
  import icap_stream_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int CNT_W          = 24,
  parameter int BIT_SWAP       = 1,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] word_count,
  input  logic [31:0]      s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic             icap_csib,
  output logic             icap_rdwrb,
  output logic [31:0]      icap_i,
  input  logic             icap_avail,
  input  logic             icap_prdone,
  input  logic             icap_prerror,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] words_sent
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [CNT_W-1:0] acc_q, acc_n;
  logic [CNT_W-1:0] words_sent_n;
  logic [TW-1:0]    timer, timer_n;
  logic             csib_n, rdwrb_n, busy_n, done_n, error_n;
  logic [31:0]      icap_i_n;
  logic [1:0]       err_code_n;
  logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [31:0]      fifo_head;
  logic             err_hit;
  logic [1:0]       err_val;

  icap_word_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk  (ACLK),
    .rst  (ARESET),
    .push (fifo_push),
    .pop  (fifo_pop),
    .flush(fifo_flush),
    .din  (s_tdata),
    .dout (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_n      = state;
    cnt_n        = cnt_q;
    acc_n        = acc_q;
    words_sent_n = words_sent;
    timer_n      = timer;
    csib_n       = icap_csib;
    rdwrb_n      = icap_rdwrb;
    icap_i_n     = icap_i;
    busy_n       = busy;
    done_n       = done;
    error_n      = error;
    err_code_n   = err_code;
    s_tready     = 1'b0;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;
    err_hit      = 1'b0;
    err_val      = ERR_NONE;

    // Error sources in priority order: PRERROR beats abort beats timeout.
    if (icap_prerror && (state inside {WRITE, HOLD, WAIT_DONE})) begin
      err_hit = 1'b1;
      err_val = ERR_PRERROR;
    end else if (abort && (state inside {SETUP, WRITE, HOLD, WAIT_DONE})) begin
      err_hit = 1'b1;
      err_val = ERR_ABORT;
    end else if (state == WAIT_DONE && timer == TW'(TIMEOUT_CYCLES - 1)) begin
      err_hit = 1'b1;
      err_val = ERR_TIMEOUT;
    end

    case (state)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            cnt_n        = word_count;
            acc_n        = '0;
            words_sent_n = '0;
            done_n       = 1'b0;
            error_n      = 1'b0;
            err_code_n   = ERR_NONE;
            busy_n       = 1'b1;
            // Direction flips to write while CSIB is still high.
            rdwrb_n      = 1'b0;
            state_n      = SETUP;
          end else begin
            words_sent_n = '0;
            done_n       = 1'b1;
            error_n      = 1'b0;
            err_code_n   = ERR_NONE;
          end
        end
      end
      SETUP: state_n = WRITE;
      WRITE: begin
        s_tready  = !fifo_full && (acc_q < cnt_q);
        fifo_push = s_tvalid && s_tready;
        if (fifo_push) acc_n = acc_q + 1'b1;
        if (words_sent == cnt_q) begin
          // Last word is on the bus this cycle; deselect before HOLD.
          csib_n  = 1'b1;
          state_n = HOLD;
        end else if (!fifo_empty && icap_avail) begin
          fifo_pop     = 1'b1;
          csib_n       = 1'b0;
          icap_i_n     = (BIT_SWAP != 0) ? bitswap32(fifo_head) : fifo_head;
          words_sent_n = words_sent + 1'b1;
        end else begin
          csib_n = 1'b1;
        end
      end
      HOLD: begin
        rdwrb_n = 1'b1;
        timer_n = '0;
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        timer_n = timer + 1'b1;
        if (icap_prdone) state_n = DONE;
      end
      DISCARD: begin
        rdwrb_n  = 1'b1;
        // Keep draining so the read master finishes its burst without stalling.
        s_tready = (acc_q < cnt_q);
        if (s_tvalid && s_tready) acc_n = acc_q + 1'b1;
        if (acc_q == cnt_q) begin
          error_n = 1'b1;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Error exit: deselect now, release RDWRB on the following cycle (DISCARD).
    if (err_hit) begin
      err_code_n   = err_val;
      csib_n       = 1'b1;
      rdwrb_n      = icap_rdwrb;
      icap_i_n     = icap_i;
      words_sent_n = words_sent;
      fifo_pop     = 1'b0;
      fifo_flush   = 1'b1;
      state_n      = DISCARD;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      words_sent <= '0;
      timer      <= '0;
      icap_csib  <= 1'b1;
      icap_rdwrb <= 1'b1;
      icap_i     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state      <= state_n;
      cnt_q      <= cnt_n;
      acc_q      <= acc_n;
      words_sent <= words_sent_n;
      timer      <= timer_n;
      icap_csib  <= csib_n;
      icap_rdwrb <= rdwrb_n;
      icap_i     <= icap_i_n;
      busy       <= busy_n;
      done       <= done_n;
      error      <= error_n;
      err_code   <= err_code_n;
    end
  end

endmodule

// File: tb/tb_icap_stream_writer.sv
// tb_icap_stream_writer
// Directed bench for icap_stream_writer: normal transfer, backpressure,
// PRERROR, timeout, abort, zero-length, ignored start, PRDONE+PRERROR,
// asynchronous reset mid-write.
module tb_icap_stream_writer;

  localparam int CNT_W = 24;

  logic             ACLK = 1'b0;
  logic             ARESET;
  logic             start, abort;
  logic [CNT_W-1:0] word_count;
  logic [31:0]      s_tdata;
  logic             s_tvalid, s_tready;
  logic             icap_csib, icap_rdwrb;
  logic [31:0]      icap_i;
  logic             icap_avail, icap_prdone, icap_prerror;
  logic             busy, done, error;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] words_sent;

  icap_stream_writer #(
    .FIFO_DEPTH(4),
    .CNT_W(CNT_W),
    .BIT_SWAP(1),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .abort(abort),
    .word_count(word_count), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb),
    .icap_i(icap_i), .icap_avail(icap_avail), .icap_prdone(icap_prdone),
    .icap_prerror(icap_prerror), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .words_sent(words_sent)
  );

  always #5 ACLK = ~ACLK;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] src [0:31];
  logic [31:0] cap_q [$];
  int          viol, bp_cnt, acc_idx, lat;

  function automatic logic [31:0] ref_swap(input logic [31:0] d);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = {d[8*k], d[8*k+1], d[8*k+2], d[8*k+3],
                     d[8*k+4], d[8*k+5], d[8*k+6], d[8*k+7]};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int n);
    @(posedge ACLK); #1;
    start = 1'b1;
    word_count = CNT_W'(n);
    @(posedge ACLK); #1;
    start = 1'b0;
  endtask

  // Streams src[0..n-1], records every CSIB-low word, and finishes when done
  // rises. fin_mode: 0 no PRDONE, 1 PRDONE, 2 PRDONE together with PRERROR.
  task automatic xfer(input int n, input bit toggle, input int err_after,
                      input int fin_mode, input int budget);
    int idx, cyc, rise_cyc;
    bit hs, seen_low, fin_fired, err_fired, prev_csib, prev_rdwrb, got_done;
    idx = 0; cyc = 0; rise_cyc = -1;
    seen_low = 0; fin_fired = 0; err_fired = 0; got_done = 0;
    prev_csib = icap_csib; prev_rdwrb = icap_rdwrb;
    cap_q.delete(); viol = 0; bp_cnt = 0; lat = -1;
    s_tvalid = (n > 0);
    s_tdata  = src[0];
    while (cyc < budget && !got_done) begin
      @(negedge ACLK);
      if (icap_csib == 1'b0) begin
        cap_q.push_back(icap_i);
        if (icap_rdwrb !== 1'b0) viol++;
      end
      if (icap_rdwrb !== prev_rdwrb && (icap_csib !== 1'b1 || prev_csib !== 1'b1)) viol++;
      if (!icap_rdwrb) seen_low = 1;
      if (seen_low && icap_rdwrb && rise_cyc < 0) rise_cyc = cyc;
      if (s_tvalid && !s_tready && cap_q.size() > 0) bp_cnt++;
      hs = s_tvalid && s_tready;
      prev_csib = icap_csib;
      prev_rdwrb = icap_rdwrb;
      if (done) begin
        got_done = 1;
        if (rise_cyc >= 0) lat = cyc - rise_cyc;
      end else begin
        if (err_after >= 0 && !err_fired && cap_q.size() == err_after) begin
          icap_prerror = 1'b1;
          err_fired = 1;
        end
        @(posedge ACLK); #1;
        cyc++;
        icap_prerror = 1'b0;
        icap_prdone  = 1'b0;
        if (hs) idx++;
        s_tvalid = (idx < n);
        s_tdata  = (idx < n) ? src[idx] : 32'h0;
        if (toggle) icap_avail = ~icap_avail;
        if (fin_mode != 0 && !fin_fired && seen_low && icap_rdwrb) begin
          icap_prdone  = 1'b1;
          icap_prerror = (fin_mode == 2);
          fin_fired = 1;
        end
      end
    end
    acc_idx = idx;
    s_tvalid = 1'b0; icap_avail = 1'b1; icap_prdone = 1'b0; icap_prerror = 1'b0;
    check("xfer_finished", 32'(got_done), 32'd1);
  endtask

  initial begin
    ARESET = 1'b1; start = 1'b0; abort = 1'b0; word_count = '0;
    s_tdata = '0; s_tvalid = 1'b0;
    icap_avail = 1'b1; icap_prdone = 1'b0; icap_prerror = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    // Reset state
    check("rst_csib", 32'(icap_csib), 32'd1);
    check("rst_rdwrb", 32'(icap_rdwrb), 32'd1);
    check("rst_icap_i", icap_i, 32'h0);
    check("rst_tready", 32'(s_tready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_words_sent", 32'(words_sent), 32'd0);
    ARESET = 1'b0;

    // Normal 4-word transfer
    src[0] = 32'h000000BB; src[1] = 32'h11220044;
    src[2] = 32'hAA995566; src[3] = 32'h20000000;
    pulse_start(4);
    check("norm_busy", 32'(busy), 32'd1);
    xfer(4, 0, -1, 1, 200);
    check("norm_ncsib", 32'(cap_q.size()), 32'd4);
    check("norm_w0", cap_q[0], 32'h000000DD);
    check("norm_w1", cap_q[1], 32'h88440022);
    check("norm_w2", cap_q[2], 32'h5599AA66);
    check("norm_w3", cap_q[3], 32'h04000000);
    check("norm_rdwrb_seq", 32'(viol), 32'd0);
    check("norm_error", 32'(error), 32'd0);
    check("norm_err_code", 32'(err_code), 32'd0);
    check("norm_words_sent", 32'(words_sent), 32'd4);
    check("norm_busy_end", 32'(busy), 32'd0);

    // Backpressure: ICAP available every other cycle, FIFO depth 4
    for (int i = 0; i < 20; i++) src[i] = 32'h1F2E3D4C ^ (32'(i) * 32'h01030507);
    pulse_start(20);
    xfer(20, 1, -1, 1, 400);
    check("bp_ncsib", 32'(cap_q.size()), 32'd20);
    for (int i = 0; i < 20; i++)
      check($sformatf("bp_word%0d", i), cap_q[i], ref_swap(src[i]));
    check("bp_stalled", 32'(bp_cnt > 0), 32'd1);
    check("bp_rdwrb_seq", 32'(viol), 32'd0);
    check("bp_words_sent", 32'(words_sent), 32'd20);
    check("bp_error", 32'(error), 32'd0);

    // PRERROR after 3 words of 10
    for (int i = 0; i < 10; i++) src[i] = 32'hC0DE0000 + 32'(i);
    pulse_start(10);
    xfer(10, 0, 3, 0, 300);
    check("prerr_ncsib", 32'(cap_q.size()), 32'd3);
    check("prerr_accepted", 32'(acc_idx), 32'd10);
    check("prerr_error", 32'(error), 32'd1);
    check("prerr_err_code", 32'(err_code), 32'd1);
    check("prerr_words_sent", 32'(words_sent), 32'd3);
    check("prerr_busy", 32'(busy), 32'd0);
    check("prerr_rdwrb_seq", 32'(viol), 32'd0);

    // Timeout: 100 cycles in WAIT_DONE, one more in DISCARD before error shows
    pulse_start(2);
    xfer(2, 0, -1, 0, 400);
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_err_code", 32'(err_code), 32'd2);
    check("tmo_latency", 32'(lat), 32'd101);
    check("tmo_words_sent", 32'(words_sent), 32'd2);

    // Zero-length transfer
    pulse_start(0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check("zero_csib", 32'(icap_csib), 32'd1);
    end

    // Start while busy is ignored
    src[0] = 32'h80402010; src[1] = 32'h01020408;
    pulse_start(2);
    pulse_start(5);
    xfer(2, 0, -1, 1, 200);
    check("busy_start_ncsib", 32'(cap_q.size()), 32'd2);
    check("busy_start_w0", cap_q[0], 32'h01020408);
    check("busy_start_w1", cap_q[1], 32'h80402010);
    check("busy_start_words_sent", 32'(words_sent), 32'd2);
    check("busy_start_error", 32'(error), 32'd0);

    // Abort: all 4 words drained and dropped
    src[0] = 32'h1; src[1] = 32'h2; src[2] = 32'h3; src[3] = 32'h4;
    pulse_start(4);
    abort = 1'b1;
    @(posedge ACLK); #1;
    abort = 1'b0;
    xfer(4, 0, -1, 0, 200);
    check("abort_ncsib", 32'(cap_q.size()), 32'd0);
    check("abort_accepted", 32'(acc_idx), 32'd4);
    check("abort_err_code", 32'(err_code), 32'd3);
    check("abort_error", 32'(error), 32'd1);

    // PRDONE and PRERROR together
    src[0] = 32'h00FF00FF;
    pulse_start(1);
    xfer(1, 0, -1, 2, 200);
    check("both_w0", cap_q[0], 32'h00FF00FF);
    check("both_err_code", 32'(err_code), 32'd1);
    check("both_error", 32'(error), 32'd1);

    // Asynchronous reset in the middle of WRITE
    for (int i = 0; i < 8; i++) src[i] = 32'hA5000000 + 32'(i);
    pulse_start(8);
    s_tvalid = 1'b1;
    s_tdata  = src[0];
    repeat (5) @(posedge ACLK);
    #1;
    check("arst_pre_csib", 32'(icap_csib), 32'd0);
    #1 ARESET = 1'b1;
    #1;
    check("arst_csib", 32'(icap_csib), 32'd1);
    check("arst_rdwrb", 32'(icap_rdwrb), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_words_sent", 32'(words_sent), 32'd0);
    s_tvalid = 1'b0;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    src[0] = 32'h12345678; src[1] = 32'hF00F0FF0;
    pulse_start(2);
    xfer(2, 0, -1, 1, 200);
    check("arst_ncsib", 32'(cap_q.size()), 32'd2);
    check("arst_w0", cap_q[0], 32'h482C6A1E);
    check("arst_w1", cap_q[1], 32'h0FF0F00F);
    check("arst_done_error", 32'(error), 32'd0);
    check("arst_words_sent2", 32'(words_sent), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
